// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the fetch unit: icodes, status codes, register-none marker
// and the instruction-length function used by the decoder.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam int         MAX_ILEN = 10;

  typedef enum logic {S_RUN, S_STOP} fstate_e;

  // Invalid icodes are treated as one byte long so they can be reported and popped.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: return 4'd2;
      I_JXX, I_CALL:                    return 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     return 4'd10;
      default:                          return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/y86_fetch_queue.sv
// Circular byte FIFO between instruction memory and the decoder: pushes FETCH_BYTES at once,
// pops a variable 1..10 bytes, and exposes the ten bytes at the head for decode.
module y86_fetch_queue
  import y86_pkg::*;
#(
  parameter int FETCH_BYTES = 8,
  parameter int QDEPTH      = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [8*FETCH_BYTES-1:0]     push_data_i,
  input  logic                         pop_i,
  input  logic [3:0]                   pop_len_i,
  output logic [8*MAX_ILEN-1:0]        head_o,
  output logic [$clog2(QDEPTH+1)-1:0]  count_o
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  logic [7:0]    mem_q [QDEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_ptr;
  logic [CW-1:0] count_q, count_d;

  // Offsets never exceed 2*QDEPTH, so a single conditional subtract is enough.
  function automatic logic [PW-1:0] wrap(input logic [31:0] idx);
    return PW'(idx >= 32'(QDEPTH) ? idx - 32'(QDEPTH) : idx);
  endfunction

  assign wr_ptr  = wrap(32'(rd_q) + 32'(count_q));
  assign count_o = count_q;

  always_comb begin
    rd_d    = rd_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (pop_i) rd_d = wrap(32'(rd_q) + 32'(pop_len_i));
      count_d = CW'(32'(count_q) + (push_i ? 32'(FETCH_BYTES) : 32'd0)
                    - (pop_i ? 32'(pop_len_i) : 32'd0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      for (int k = 0; k < FETCH_BYTES; k++)
        mem_q[wrap(32'(wr_ptr) + 32'(k))] <= push_data_i[8*k +: 8];
    end
  end

  always_comb begin
    head_o = '0;
    for (int k = 0; k < MAX_ILEN; k++)
      head_o[8*k +: 8] = mem_q[wrap(32'(rd_q) + 32'(k))];
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Y86-64 prefetching fetch stage with valid/ready hand-off to decode and redirect support.
// Optional Y86_BRANCH_PREDICT_EN: jXX/call are predicted taken and fetch follows valC.
module y86_fetch_unit
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          FETCH_BYTES = 8,
  parameter int          QDEPTH      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [63:0]              imem_addr,
  input  logic                     imem_rvalid,
  input  logic [8*FETCH_BYTES-1:0] imem_rdata,
  input  logic                     imem_err,
  input  logic                     redirect_vld,
  input  logic [63:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [3:0]               icode,
  output logic [3:0]               ifun,
  output logic [3:0]               rA,
  output logic [3:0]               rB,
  output logic [63:0]              valC,
  output logic [63:0]              valP,
  output logic [2:0]               stat
);
  localparam int CW = $clog2(QDEPTH + 1);

  fstate_e              state_q, state_d;
  logic [63:0]          fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d, redir_pc;
  logic                 outst_q, outst_d, stale_q, stale_d, err_q, err_d;
  logic [8*MAX_ILEN-1:0] head;
  logic [CW-1:0]        count;
  logic [3:0]           hd_icode, len;
  logic                 have, accept, full_instr, bp_taken, redir_any, q_push;

  y86_fetch_queue #(.FETCH_BYTES(FETCH_BYTES), .QDEPTH(QDEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redir_any),
    .push_i      (q_push),
    .push_data_i (imem_rdata),
    .pop_i       (full_instr),
    .pop_len_i   (len),
    .head_o      (head),
    .count_o     (count)
  );

  assign hd_icode = head[7:4];
  assign len      = instr_len(hd_icode);
  assign have     = 32'(count) >= 32'(len);
  assign out_pc   = out_pc_q;

  always_comb begin
    out_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0;
    valC = '0; valP = '0; stat = '0;
    if (state_q == S_RUN && have) begin
      out_valid = 1'b1;
      icode = head[7:4];
      ifun  = head[3:0];
      rA    = REG_NONE;
      rB    = REG_NONE;
      valP  = out_pc_q + 64'(len);
      case (len)
        4'd2:  begin rA = head[15:12]; rB = head[11:8]; end
        4'd9:  valC = head[71:8];
        4'd10: begin rA = head[15:12]; rB = head[11:8]; valC = head[79:16]; end
        default: ;
      endcase
      stat = (hd_icode > I_POPQ) ? STAT_INS : (hd_icode == I_HALT) ? STAT_HLT : STAT_AOK;
    end else if (state_q == S_RUN && err_q) begin
      // Head cannot be completed because memory faulted: report the address error at head PC.
      out_valid = 1'b1;
      stat      = STAT_ADR;
    end
  end

  assign accept     = out_valid && out_ready && !redirect_vld;
  assign full_instr = accept && have;
`ifdef Y86_BRANCH_PREDICT_EN
  assign bp_taken   = full_instr && (hd_icode == I_JXX || hd_icode == I_CALL);
`else
  assign bp_taken   = 1'b0;
`endif
  assign redir_any  = redirect_vld || bp_taken;
  assign redir_pc   = redirect_vld ? redirect_pc : valC;
  assign imem_req   = !rst && state_q == S_RUN && !outst_q && !err_q && !redir_any &&
                      (32'(QDEPTH) - 32'(count) >= 32'(FETCH_BYTES));
  assign imem_addr  = imem_req ? fetch_pc_q : '0;
  assign q_push     = imem_rvalid && outst_q && !stale_q && !imem_err;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_pc_d   = out_pc_q;
    outst_d    = outst_q;
    stale_d    = stale_q;
    err_d      = err_q;
    if (imem_rvalid) begin
      outst_d = 1'b0;
      stale_d = 1'b0;
      if (outst_q && !stale_q && imem_err) err_d = 1'b1;
    end
    if (imem_req) begin
      outst_d    = 1'b1;
      fetch_pc_d = fetch_pc_q + 64'(FETCH_BYTES);
    end
    if (accept && stat != STAT_AOK) state_d = S_STOP;
    if (full_instr) out_pc_d = valP;
    if (redir_any) begin
      err_d      = 1'b0;
      fetch_pc_d = redir_pc;
      out_pc_d   = redir_pc;
      state_d    = S_RUN;
      if (outst_q && !imem_rvalid) stale_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= RESET_PC;
      outst_q    <= 1'b0;
      stale_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Scoreboard bench for y86_fetch_unit: a byte memory with programmable latency/fault window
// answers fetches, expected decode records are queued per scenario and compared on transfer.
module tb_y86_fetch_unit;
  localparam int FB = 8;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
  } rec_t;

  logic          clk = 1'b0, rst = 1'b1;
  logic          imem_req, imem_rvalid = 1'b0, imem_err = 1'b0;
  logic [63:0]   imem_addr;
  logic [8*FB-1:0] imem_rdata = '0;
  logic          redirect_vld = 1'b0, out_valid, out_ready = 1'b1;
  logic [63:0]   redirect_pc = '0, out_pc, valC, valP;
  logic [3:0]    icode, ifun, rA, rB;
  logic [2:0]    stat;

  logic [7:0]    mem [0:4095];
  logic [63:0]   err_base = '1, paddr = '0;
  int            lat = 1, cnt = 0;
  logic          pend = 1'b0;
  rec_t          exp_q[$];
  int            n_chk = 0, n_pass = 0;

  y86_fetch_unit #(.RESET_PC(64'h0), .FETCH_BYTES(FB), .QDEPTH(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .valP(valP), .stat(stat)
  );

  always #5 clk = ~clk;

  // Instruction memory: one outstanding request, response 'lat' cycles after the request.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    if (rst) pend = 1'b0;
    else begin
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend        = 1'b0;
          imem_rvalid = 1'b1;
          imem_err    = (paddr >= err_base);
          for (int k = 0; k < FB; k++) imem_rdata[8*k +: 8] = mem[12'(paddr + 64'(k))];
        end
      end
      if (imem_req) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = imem_addr;
      end
    end
  end

  function automatic rec_t mk(input logic [63:0] pc, input logic [3:0] ic, fn, ra, rb,
                              input logic [63:0] vc, vp, input logic [2:0] st);
    mk = '{pc, ic, fn, ra, rb, vc, vp, st};
  endfunction

  task automatic wr64(input int addr, input logic [63:0] v);
    for (int k = 0; k < 8; k++) mem[addr + k] = v[8*k +: 8];
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    exp_q.delete();
    lat = 1; err_base = '1; out_ready = 1'b1; redirect_vld = 1'b0; redirect_pc = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(output logic x, output rec_t r, output logic rq);
    @(negedge clk);
    x  = out_valid && out_ready && !redirect_vld && !rst;
    r  = '{out_pc, icode, ifun, rA, rB, valC, valP, stat};
    rq = imem_req;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_all();
    mem[0] = 8'h30; mem[1] = 8'hf2; mem[2] = 8'h0a;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b exp 0", imem_req); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (out_pc !== 64'h0) $display("FAIL rst_pc got %h exp 0", out_pc); else n_pass++;
    n_chk++; if (stat !== 3'd0) $display("FAIL rst_stat got %0d exp 0", stat); else n_pass++;
    n_chk++; if (valP !== 64'h0) $display("FAIL rst_valp got %h exp 0", valP); else n_pass++;
    n_chk++; if (imem_addr !== 64'h0) $display("FAIL rst_addr got %h exp 0", imem_addr); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (imem_req !== 1'b1) $display("FAIL first_req got %b exp 1", imem_req); else n_pass++;
    n_chk++; if (imem_addr !== 64'h0) $display("FAIL first_addr got %h exp 0", imem_addr); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_irmovq();
    logic x, rq; rec_t r, e;
    exp_q.push_back(mk(64'd0, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, AOK));
    exp_q.push_back(mk(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, HLT));
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL irmovq got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL irmovq_done left %0d exp 0", exp_q.size());
  endtask

  task automatic test_nop_stream();
    logic x, rq; rec_t r, e; int reqs, vals;
    clear_all();
    for (int i = 0; i < 10; i++) begin
      mem[i] = 8'h10;
      exp_q.push_back(mk(64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), AOK));
    end
    exp_q.push_back(mk(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, HLT));
    do_reset();
    for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
      out_ready = ($urandom_range(0, 1) == 1);
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL nop_stream got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL nop_done left %0d exp 0", exp_q.size());
    out_ready = 1'b1; reqs = 0; vals = 0;
    for (int c = 0; c < 12; c++) begin
      step(x, r, rq);
      if (rq) reqs++;
      if (r.stat != 3'd0 || out_valid) vals++;
    end
    n_chk++; if (reqs != 0) $display("FAIL halt_noreq got %0d exp 0", reqs); else n_pass++;
    n_chk++; if (vals != 0) $display("FAIL halt_novalid got %0d exp 0", vals); else n_pass++;
  endtask

  task automatic test_mix();
    logic x, rq; rec_t r, e;
    clear_all();
    mem[0] = 8'h20; mem[1] = 8'h12;
    mem[2] = 8'h50; mem[3] = 8'h34; wr64(4, 64'h0102030405060708);
    mem[12] = 8'ha0; mem[13] = 8'h4f; mem[14] = 8'h90; mem[15] = 8'hb0; mem[16] = 8'h5f;
    exp_q.push_back(mk(64'd0,  4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd2, AOK));
    exp_q.push_back(mk(64'd2,  4'h5, 4'h0, 4'h3, 4'h4, 64'h0102030405060708, 64'd12, AOK));
    exp_q.push_back(mk(64'd12, 4'hA, 4'h0, 4'h4, 4'hF, 64'd0, 64'd14, AOK));
    exp_q.push_back(mk(64'd14, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd15, AOK));
    exp_q.push_back(mk(64'd15, 4'hB, 4'h0, 4'h5, 4'hF, 64'd0, 64'd17, AOK));
    exp_q.push_back(mk(64'd17, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd18, HLT));
    do_reset();
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL mix got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL mix_done left %0d exp 0", exp_q.size());
  endtask

  task automatic test_invalid_redirect();
    logic x, rq; rec_t r, e; int vals;
    clear_all();
    mem[0] = 8'hC0; mem[8'h40] = 8'h60; mem[8'h41] = 8'h23;
    exp_q.push_back(mk(64'd0, 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, INS));
    do_reset();
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL ins got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL ins_done left %0d exp 0", exp_q.size());
    vals = 0;
    for (int c = 0; c < 6; c++) begin
      step(x, r, rq);
      if (out_valid || rq) vals++;
    end
    n_chk++; if (vals != 0) $display("FAIL ins_stop got %0d exp 0", vals); else n_pass++;
    exp_q.push_back(mk(64'h40, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'h42, AOK));
    exp_q.push_back(mk(64'h42, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h43, HLT));
    redirect_vld = 1'b1; redirect_pc = 64'h40;
    step(x, r, rq);
    redirect_vld = 1'b0;
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL resume got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL resume_done left %0d exp 0", exp_q.size());
  endtask

  task automatic test_imem_err();
    logic x, rq; rec_t r, e;
    clear_all();
    for (int i = 0; i < 6; i++) begin
      mem[i] = 8'h10;
      exp_q.push_back(mk(64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'(i + 1), AOK));
    end
    mem[6] = 8'h40; mem[7] = 8'h12; wr64(8, 64'h1111_2222_3333_4444);
    exp_q.push_back(mk(64'd6, 4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, ADR));
    err_base = 64'd8;
    do_reset();
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL imem_err got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL err_done left %0d exp 0", exp_q.size());
  endtask

  task automatic test_redirect_stale();
    logic x, rq; rec_t r, e;
    clear_all();
    lat = 5;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10;
    mem[8'h80] = 8'h74; wr64(8'h81, 64'h100);
    exp_q.push_back(mk(64'h80, 4'h7, 4'h4, 4'hF, 4'hF, 64'h100, 64'h89, AOK));
`ifdef Y86_BRANCH_PREDICT_EN
    exp_q.push_back(mk(64'h100, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h101, HLT));
`else
    exp_q.push_back(mk(64'h89, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h8A, HLT));
`endif
    do_reset();
    step(x, r, rq);
    n_chk++; if (rq !== 1'b1) $display("FAIL stale_req0 got %b exp 1", rq); else n_pass++;
    redirect_vld = 1'b1; redirect_pc = 64'h80;
    step(x, r, rq);
    redirect_vld = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL stale got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL stale_done left %0d exp 0", exp_q.size());
  endtask

  task automatic test_branch();
    logic x, rq; rec_t r, e;
    clear_all();
    mem[0] = 8'h80; wr64(1, 64'h100);
    exp_q.push_back(mk(64'd0, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'd9, AOK));
`ifdef Y86_BRANCH_PREDICT_EN
    exp_q.push_back(mk(64'h100, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h101, HLT));
`else
    exp_q.push_back(mk(64'd9, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd10, HLT));
`endif
    do_reset();
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      step(x, r, rq);
      if (x) begin
        e = exp_q.pop_front(); n_chk++;
        if (r === e) n_pass++; else $display("FAIL branch got %h exp %h", r, e);
      end
    end
    n_chk++;
    if (exp_q.size() == 0) n_pass++; else $display("FAIL branch_done left %0d exp 0", exp_q.size());
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_nop_stream();
    test_mix();
    test_invalid_redirect();
    test_imem_err();
    test_redirect_stale();
    test_branch();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
